// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the millisecond stopwatch:
//   sw_state_e            - control state encoding (IDLE, RUN, HOLD)
//   CYCLES_PER_MS_PER_MHZ - clk cycles per millisecond for each MHz of clock
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int CYCLES_PER_MS_PER_MHZ = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sw_state_e;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Millisecond prescaler. Counts 0..P-1 while en is high, wraps to 0 after P-1
// and flags the wrap cycle on tick. sync_clr forces the count back to 0 and
// wins over en.
// Parameters:
//   P        - clk cycles per tick (>= 2)
// Ports:
//   clk      in   clock, posedge
//   rst_n    in   synchronous active-low reset
//   en       in   count enable
//   sync_clr in   synchronous clear of the count
//   tick     out  high in the cycle the count wraps from P-1 to 0
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int P = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int            PW   = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] LAST = PW'(P - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          wrap_s;

  assign wrap_s = en && (cnt_q == LAST);
  assign tick   = wrap_s;

  // Next prescaler count: clear, wrap, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = {PW{1'b0}};
    end else if (wrap_s) begin
      cnt_d = {PW{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {PW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_gen

// File: rtl/stopwatch.sv
// -----------------------------------------------------------------------------
// stopwatch
// Millisecond stopwatch with IDLE / RUN / HOLD control. Counts whole
// milliseconds while running, holds the final count after stop and reports
// the end of a measurement with a one-cycle result_valid pulse. The count
// saturates at all-ones and sets a sticky overflow flag.
// Parameters:
//   CLK_FREQ_MHZ  - clock frequency in MHz (P = CLK_FREQ_MHZ*1000 cycles/ms)
//   CNT_W         - width of the millisecond count
// Ports:
//   clk           in   clock, posedge
//   rst_n         in   synchronous active-low reset
//   start         in   begin / restart a measurement
//   stop          in   end the current measurement
//   clear         in   abort to IDLE and zero all results (highest priority)
//   elapsed_ms    out  live count in RUN, held result otherwise
//   running       out  high while in RUN
//   result_valid  out  one-cycle pulse on the first HOLD cycle
//   overflow      out  sticky saturation flag for the current/last measurement
// Optional (macro STOPWATCH_LAP_EN):
//   lap           in   capture the live count without disturbing the run
//   lap_ms        out  last captured lap count
//   lap_valid     out  one-cycle pulse when lap_ms is updated
// -----------------------------------------------------------------------------
module stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [CNT_W-1:0] elapsed_ms,
  output logic             running,
  output logic             result_valid,
  output logic             overflow
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic             lap,
  output logic [CNT_W-1:0] lap_ms,
  output logic             lap_valid
`endif
);

  localparam int P = CLK_FREQ_MHZ * CYCLES_PER_MS_PER_MHZ;

  // Saturating increment: MSB of the result flags that v was already at max.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = {1'b1, v};
    end else begin
      r = {1'b0, v + 1'b1};
    end
    return r;
  endfunction

  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             overflow_q, overflow_d;
  logic             running_q, running_d;
  logic             result_valid_q, result_valid_d;

  logic             tick_s;
  logic             presc_en_s;
  logic             presc_clr_s;
  logic [CNT_W:0]   inc_s;
  logic [CNT_W-1:0] count_next_s;
  logic             sat_s;

  // The prescaler only advances in RUN; any (re)start or abort zeroes it.
  assign presc_en_s = (state_q == RUN);

  tick_gen #(
    .P (P)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (presc_en_s),
    .sync_clr (presc_clr_s),
    .tick     (tick_s)
  );

  // Live count including this cycle's tick, so a tick that lands on the
  // stop (or lap) cycle is part of the captured value.
  always_comb begin
    inc_s = {1'b0, elapsed_q};
    if (tick_s) begin
      inc_s = sat_inc(elapsed_q);
    end else begin
      inc_s = {1'b0, elapsed_q};
    end
    count_next_s = inc_s[CNT_W-1:0];
    sat_s        = inc_s[CNT_W];
  end

  // Control state machine: next state, count, overflow and result pulse.
  always_comb begin
    state_d        = state_q;
    elapsed_d      = elapsed_q;
    overflow_d     = overflow_q;
    result_valid_d = 1'b0;
    presc_clr_s    = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      elapsed_d   = {CNT_W{1'b0}};
      overflow_d  = 1'b0;
      presc_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = RUN;
            elapsed_d   = {CNT_W{1'b0}};
            overflow_d  = 1'b0;
            presc_clr_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          // stop wins over a simultaneous start
          if (stop) begin
            state_d        = HOLD;
            elapsed_d      = count_next_s;
            overflow_d     = overflow_q | sat_s;
            result_valid_d = 1'b1;
          end else if (start) begin
            state_d     = RUN;
            elapsed_d   = {CNT_W{1'b0}};
            overflow_d  = 1'b0;
            presc_clr_s = 1'b1;
          end else begin
            state_d    = RUN;
            elapsed_d  = count_next_s;
            overflow_d = overflow_q | sat_s;
          end
        end
        HOLD: begin
          if (start) begin
            state_d     = RUN;
            elapsed_d   = {CNT_W{1'b0}};
            overflow_d  = 1'b0;
            presc_clr_s = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = IDLE;
          elapsed_d   = {CNT_W{1'b0}};
          overflow_d  = 1'b0;
          presc_clr_s = 1'b1;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

`ifdef STOPWATCH_LAP_EN
  logic [CNT_W-1:0] lap_ms_q, lap_ms_d;
  logic             lap_valid_q, lap_valid_d;

  // Lap capture: only a plain RUN cycle (no stop, no clear) takes a snapshot.
  always_comb begin
    lap_ms_d    = lap_ms_q;
    lap_valid_d = 1'b0;
    if (clear) begin
      lap_ms_d = {CNT_W{1'b0}};
    end else if ((state_q == RUN) && lap && !stop) begin
      lap_ms_d    = count_next_s;
      lap_valid_d = 1'b1;
    end else begin
      lap_ms_d = lap_ms_q;
    end
  end

  assign lap_ms    = lap_ms_q;
  assign lap_valid = lap_valid_q;
`else
  // Lap capture is not built in this configuration.
`endif

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      elapsed_q      <= {CNT_W{1'b0}};
      overflow_q     <= 1'b0;
      running_q      <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_ms_q       <= {CNT_W{1'b0}};
      lap_valid_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      elapsed_q      <= elapsed_d;
      overflow_q     <= overflow_d;
      running_q      <= running_d;
      result_valid_q <= result_valid_d;
`ifdef STOPWATCH_LAP_EN
      lap_ms_q       <= lap_ms_d;
      lap_valid_q    <= lap_valid_d;
`endif
    end
  end

  assign elapsed_ms   = elapsed_q;
  assign running      = running_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule : stopwatch

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch at CLK_FREQ_MHZ=1 (P=1000 cycles per ms).
// Two instances share the stimulus: a (CNT_W=16) and b (CNT_W=4, for
// saturation). Inputs change 1 time unit after posedge; checks are made there.
module tb_stopwatch;

  localparam int P = 1000;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, clear;
  logic [15:0] a_elapsed;
  logic        a_running, a_rv, a_ovf;
  logic [3:0]  b_elapsed;
  logic        b_running, b_rv, b_ovf;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
  logic [15:0] a_lap_ms;
  logic        a_lap_valid;
  logic [3:0]  b_lap_ms;
  logic        b_lap_valid;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch #(.CLK_FREQ_MHZ(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .elapsed_ms(a_elapsed), .running(a_running), .result_valid(a_rv),
    .overflow(a_ovf)
`ifdef STOPWATCH_LAP_EN
    , .lap(lap), .lap_ms(a_lap_ms), .lap_valid(a_lap_valid)
`endif
  );

  stopwatch #(.CLK_FREQ_MHZ(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .elapsed_ms(b_elapsed), .running(b_running), .result_valid(b_rv),
    .overflow(b_ovf)
`ifdef STOPWATCH_LAP_EN
    , .lap(lap), .lap_ms(b_lap_ms), .lap_valid(b_lap_valid)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    // Reset state
    step(2);
    check("rst_elapsed", 32'(a_elapsed), 32'd0);
    check("rst_running", 32'(a_running), 32'd0);
    check("rst_rv",      32'(a_rv),      32'd0);
    check("rst_ovf",     32'(a_ovf),     32'd0);
    rst_n = 1'b1;

    // Stop ignored in IDLE
    stop = 1'b1; step(1); stop = 1'b0;
    check("idle_stop_running", 32'(a_running), 32'd0);
    check("idle_stop_rv",      32'(a_rv),      32'd0);

    // Start at 0, stop at 3500
    start = 1'b1; step(1); start = 1'b0;
    check("m1_running", 32'(a_running), 32'd1);
    check("m1_elapsed0", 32'(a_elapsed), 32'd0);
    step(P - 1);
    check("m1_before_first_ms", 32'(a_elapsed), 32'd0);
    step(1);
    check("m1_first_ms", 32'(a_elapsed), 32'd1);
    step(3499 - P);
    stop = 1'b1; step(1); stop = 1'b0;
    check("m1_rv",      32'(a_rv),      32'd1);
    check("m1_result",  32'(a_elapsed), 32'd3);
    check("m1_running", 32'(a_running), 32'd0);
    step(1);
    check("m1_rv_one_cycle", 32'(a_rv), 32'd0);

    // Stop ignored in HOLD
    stop = 1'b1; step(1); stop = 1'b0;
    check("hold_stop_rv",   32'(a_rv),      32'd0);
    check("hold_stop_held", 32'(a_elapsed), 32'd3);

    // Start from HOLD, then start+stop together -> stop wins
    start = 1'b1; step(1); start = 1'b0;
    check("m2_restart_elapsed", 32'(a_elapsed), 32'd0);
    check("m2_running",         32'(a_running), 32'd1);
    step(2000);
    check("m2_2ms", 32'(a_elapsed), 32'd2);
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    check("m2_both_rv",      32'(a_rv),      32'd1);
    check("m2_both_running", 32'(a_running), 32'd0);
    check("m2_both_result",  32'(a_elapsed), 32'd2);
    start = 1'b1; step(1); start = 1'b0;
    check("m3_start_elapsed", 32'(a_elapsed), 32'd0);
    check("m3_start_running", 32'(a_running), 32'd1);

    // Restart while in RUN zeroes count and prescaler
    step(1500);
    check("m3_1ms", 32'(a_elapsed), 32'd1);
    start = 1'b1; step(1); start = 1'b0;
    check("m3_restart_zero", 32'(a_elapsed), 32'd0);
    step(P - 1);
    check("m3_restart_before", 32'(a_elapsed), 32'd0);
    step(1);
    check("m3_restart_tick", 32'(a_elapsed), 32'd1);

    // Stop coinciding with a tick includes that tick
    step(P - 1);
    stop = 1'b1; step(1); stop = 1'b0;
    check("tickstop_rv",     32'(a_rv),      32'd1);
    check("tickstop_result", 32'(a_elapsed), 32'd2);

    // Clear with stop at count 5 -> IDLE, zero, no pulse
    start = 1'b1; step(1); start = 1'b0;
    step(5200);
    check("clr_pre_count", 32'(a_elapsed), 32'd5);
    clear = 1'b1; stop = 1'b1; step(1); clear = 1'b0; stop = 1'b0;
    check("clr_elapsed", 32'(a_elapsed), 32'd0);
    check("clr_running", 32'(a_running), 32'd0);
    check("clr_rv",      32'(a_rv),      32'd0);
    step(1);
    check("clr_rv_later", 32'(a_rv), 32'd0);

    // Reset mid-RUN at count 7, then start immediately after
    start = 1'b1; step(1); start = 1'b0;
    step(7300);
    check("rst_pre_count", 32'(a_elapsed), 32'd7);
    rst_n = 1'b0; step(1);
    check("midrst_elapsed", 32'(a_elapsed), 32'd0);
    check("midrst_running", 32'(a_running), 32'd0);
    check("midrst_rv",      32'(a_rv),      32'd0);
    check("midrst_ovf",     32'(a_ovf),     32'd0);
    rst_n = 1'b1; start = 1'b1; step(1); start = 1'b0;
    check("postrst_running", 32'(a_running), 32'd1);
    step(P - 1);
    check("postrst_before", 32'(a_elapsed), 32'd0);
    step(1);
    check("postrst_first_ms", 32'(a_elapsed), 32'd1);

    // Saturation on the 4-bit instance
    clear = 1'b1; step(1); clear = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(15000);
    check("sat_b_15",      32'(b_elapsed), 32'd15);
    check("sat_b_ovf_pre", 32'(b_ovf),     32'd0);
    step(1000);
    check("sat_b_hold15", 32'(b_elapsed), 32'd15);
    check("sat_b_ovf",    32'(b_ovf),     32'd1);
    step(4000);
    check("sat_a_20",      32'(a_elapsed), 32'd20);
    check("sat_a_ovf",     32'(a_ovf),     32'd0);
    check("sat_b_still",   32'(b_elapsed), 32'd15);
    check("sat_b_running", 32'(b_running), 32'd1);
    stop = 1'b1; step(1); stop = 1'b0;
    check("sat_b_rv",       32'(b_rv),  32'd1);
    check("sat_b_ovf_held", 32'(b_ovf), 32'd1);
    start = 1'b1; step(1); start = 1'b0;
    check("sat_b_ovf_cleared", 32'(b_ovf),     32'd0);
    check("sat_b_restart",     32'(b_elapsed), 32'd0);

`ifdef STOPWATCH_LAP_EN
    // Lap at 2.5 ms, stop at 4.2 ms
    clear = 1'b1; step(1); clear = 1'b0;
    check("lap_cleared", 32'(a_lap_ms), 32'd0);
    start = 1'b1; step(1); start = 1'b0;
    step(2500);
    lap = 1'b1; step(1); lap = 1'b0;
    check("lap_valid", 32'(a_lap_valid), 32'd1);
    check("lap_ms",    32'(a_lap_ms),    32'd2);
    step(1);
    check("lap_valid_pulse", 32'(a_lap_valid), 32'd0);
    step(4200 - 2502);
    stop = 1'b1; step(1); stop = 1'b0;
    check("lap_result",  32'(a_elapsed), 32'd4);
    check("lap_held_ms", 32'(a_lap_ms),  32'd2);
    lap = 1'b1; step(1); lap = 1'b0;
    check("lap_hold_ignored", 32'(a_lap_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_stopwatch
